// File: rtl/ipm2t_hssthp_rxlane_rst_seq.sv
// HSSTHP RX lane reset sequencer: per-lane PMA/PCS reset FSM with CDR lock
// qualification, plus 2-flop synchronizers for the asynchronous lock inputs.

module ipm2t_hssthp_rxlane_rst_seq_lane #(
    parameter int PMA_RST_CYC     = 16,
    parameter int CDR_STABLE_CYC  = 1024,
    parameter int PCS_RST_CYC     = 16,
    parameter int CDR_TIMEOUT_CYC = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_rst,
    input  logic pll_s,
    input  logic sig_s,
    input  logic cdr_s,
    output logic pma_rst,
    output logic pcs_rst,
    output logic done
);
    localparam logic [4:0] S_PMA    = 5'b00001;
    localparam logic [4:0] S_WAIT   = 5'b00010;
    localparam logic [4:0] S_STABLE = 5'b00100;
    localparam logic [4:0] S_PCS    = 5'b01000;
    localparam logic [4:0] S_DONE   = 5'b10000;

    localparam logic [15:0] PMA_LAST    = 16'(PMA_RST_CYC - 1);
    localparam logic [15:0] STABLE_LAST = 16'(CDR_STABLE_CYC - 1);
    localparam logic [15:0] PCS_LAST    = 16'(PCS_RST_CYC - 1);
    localparam logic [15:0] TO_LAST     = 16'(CDR_TIMEOUT_CYC - 1);

    logic [4:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        lock_ok;

    assign lock_ok = pll_s & sig_s & cdr_s;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        if (rx_rst) begin
            state_d = S_PMA;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_PMA:    if (cnt_q == PMA_LAST) state_d = S_WAIT;
                S_WAIT: begin
                    if (lock_ok)                 state_d = S_STABLE;
                    else if (cnt_q == TO_LAST)   state_d = S_PMA;
                end
                // Loss of lock wins over the qualification count expiring.
                S_STABLE: begin
                    if (!lock_ok)                  state_d = S_WAIT;
                    else if (cnt_q == STABLE_LAST) state_d = S_PCS;
                end
                S_PCS: begin
                    if (!lock_ok)                state_d = S_WAIT;
                    else if (cnt_q == PCS_LAST)  state_d = S_DONE;
                end
                S_DONE: begin
                    cnt_d = cnt_q;
                    if (!pll_s)                  state_d = S_PMA;
                    else if (!sig_s || !cdr_s)   state_d = S_WAIT;
                end
                default:                         state_d = S_PMA;
            endcase
            if (state_d != state_q) cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_PMA;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pma_rst = state_q[0];
    assign pcs_rst = |state_q[3:0];
    assign done    = state_q[4];
endmodule

module ipm2t_hssthp_rxlane_rst_seq #(
    parameter string CH0_RX_ENABLE   = "TRUE",
    parameter string CH1_RX_ENABLE   = "TRUE",
    parameter string CH2_RX_ENABLE   = "TRUE",
    parameter string CH3_RX_ENABLE   = "TRUE",
    parameter int    PMA_RST_CYC     = 16,
    parameter int    CDR_STABLE_CYC  = 1024,
    parameter int    PCS_RST_CYC     = 16,
    parameter int    CDR_TIMEOUT_CYC = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_rx_rst,
    input  logic [3:0] i_pll_lock,
    input  logic [3:0] i_sigdet,
    input  logic [3:0] i_cdr_align,
    output logic [3:0] o_rxlane_pma_rst,
    output logic [3:0] o_rxlane_pcs_rst,
    output logic [3:0] o_cdr_align,
    output logic [3:0] o_rxlane_done
);
    localparam logic [3:0] LANE_EN = {CH3_RX_ENABLE == "TRUE", CH2_RX_ENABLE == "TRUE",
                                      CH1_RX_ENABLE == "TRUE", CH0_RX_ENABLE == "TRUE"};

    logic [3:0] pll_q1, pll_s, sig_q1, sig_s, cdr_q1, cdr_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pll_q1 <= '0;
            pll_s  <= '0;
            sig_q1 <= '0;
            sig_s  <= '0;
            cdr_q1 <= '0;
            cdr_s  <= '0;
        end else begin
            pll_q1 <= i_pll_lock;
            pll_s  <= pll_q1;
            sig_q1 <= i_sigdet;
            sig_s  <= sig_q1;
            cdr_q1 <= i_cdr_align;
            cdr_s  <= cdr_q1;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        if (LANE_EN[g]) begin : g_en
            ipm2t_hssthp_rxlane_rst_seq_lane #(
                .PMA_RST_CYC    (PMA_RST_CYC),
                .CDR_STABLE_CYC (CDR_STABLE_CYC),
                .PCS_RST_CYC    (PCS_RST_CYC),
                .CDR_TIMEOUT_CYC(CDR_TIMEOUT_CYC)
            ) u_lane (
                .clk    (clk),
                .rst    (rst),
                .rx_rst (i_rx_rst[g]),
                .pll_s  (pll_s[g]),
                .sig_s  (sig_s[g]),
                .cdr_s  (cdr_s[g]),
                .pma_rst(o_rxlane_pma_rst[g]),
                .pcs_rst(o_rxlane_pcs_rst[g]),
                .done   (o_rxlane_done[g])
            );
            assign o_cdr_align[g] = cdr_s[g];
        end else begin : g_dis
            // Disabled lane is parked in reset; its inputs are ignored.
            logic unused_lane;
            assign unused_lane         = ^{i_rx_rst[g], pll_s[g], sig_s[g], cdr_s[g]};
            assign o_rxlane_pma_rst[g] = 1'b1;
            assign o_rxlane_pcs_rst[g] = 1'b1;
            assign o_rxlane_done[g]    = 1'b0;
            assign o_cdr_align[g]      = 1'b0;
        end
    end
endmodule

// File: doc/ipm2t_hssthp_rxlane_rst_seq.md
# ipm2t_hssthp_rxlane_rst_seq

Per-lane RX reset sequencer for the four HSSTHP lanes. It drives each lane's PMA RX reset and PCS RX reset and runs the lane through CDR lock qualification. It publishes a synchronized `o_cdr_align` and a `o_rxlane_done` flag. These feed the `cdr_align` and `rxlane_done` inputs of the downstream TX/RX FIFO-clear stage.

## Interface
- `CH0_RX_ENABLE`..`CH3_RX_ENABLE`, "TRUE": "FALSE" removes that lane's sequencer and holds its outputs at their disabled values.
- `PMA_RST_CYC`, 16: cycles the PMA RX reset is held. Range 1..65535.
- `CDR_STABLE_CYC`, 1024: consecutive cycles of lock required before the PCS reset is released. Range 1..65535.
- `PCS_RST_CYC`, 16: cycles the PCS RX reset is held after lock qualifies. Range 1..65535.
- `CDR_TIMEOUT_CYC`, 65535: cycles allowed in WAIT_LOCK before the lane retries the PMA reset. Range 1..65535.

Ports:
- `clk` input 1: free-running reference clock. Everything is in this domain.
- `rst` input 1: asynchronous, active-high block reset. This is already decided.
- `i_rx_rst` input 4: per-lane soft reset request, synchronous to `clk`, level-sensitive.
- `i_pll_lock` input 4: PLL lock per lane. Asynchronous.
- `i_sigdet` input 4: signal detect per lane. Asynchronous.
- `i_cdr_align` input 4: CDR aligned per lane. Asynchronous.
- `o_rxlane_pma_rst` output 4: PMA RX reset, active-high.
- `o_rxlane_pcs_rst` output 4: PCS RX reset, active-high.
- `o_cdr_align` output 4: synchronized CDR align, sent to the FIFO-clear stage.
- `o_rxlane_done` output 4: lane fully out of reset and locked.

## Operation
- Each asynchronous input passes through a 2-flop synchronizer: `pll_s`, `sig_s`, `cdr_s`.
  - `lock_ok[i] = pll_s[i] & sig_s[i] & cdr_s[i]`.
  - `o_cdr_align[i] = cdr_s[i]` for enabled lanes, otherwise 0.
- Each lane has an independent one-hot FSM and a 16-bit counter `cnt`. `cnt` clears on every state transition.
- Outputs are decoded directly from the one-hot state register (pma_rst / pcs_rst / done):
  - PMA_RST = 1/1/0
  - WAIT_LOCK = 0/1/0
  - STABLE = 0/1/0
  - PCS_RST = 0/1/0
  - DONE = 0/0/1
- PMA_RST: `cnt` increments each cycle. When `cnt == PMA_RST_CYC-1`, go to WAIT_LOCK.
- WAIT_LOCK: `cnt` increments each cycle.
  - If `lock_ok`, go to STABLE.
  - Else if `cnt == CDR_TIMEOUT_CYC-1`, go to PMA_RST (retry).
- STABLE: `cnt` increments while `lock_ok`.
  - If `!lock_ok`, go to WAIT_LOCK.
  - Else if `cnt == CDR_STABLE_CYC-1`, go to PCS_RST.
- PCS_RST: `cnt` increments.
  - If `!lock_ok`, go to WAIT_LOCK.
  - Else if `cnt == PCS_RST_CYC-1`, go to DONE.
- DONE: holds indefinitely.
  - If `!pll_s`, go to PMA_RST.
  - Else if `!sig_s | !cdr_s`, go to WAIT_LOCK.
- Priority, highest first: `rst` > `i_rx_rst[i]` > the transitions above.
  - `i_rx_rst[i]=1` forces PMA_RST with `cnt=0` every cycle it is high.
  - Sequencing restarts on the first cycle after it falls.
- Lanes never interact. A reset or loss of lock on one lane leaves the other lanes' states untouched.
- Disabled lane: no FSM is instantiated. pma_rst=1, pcs_rst=1, done=0 and `o_cdr_align=0`, constant.
- The counter never wraps. Every exit compare happens at or below 65534, so a 16-bit counter is sufficient.

## Timing
- Reset values, with `rst` asserted: `o_rxlane_pma_rst=4'hF`, `o_rxlane_pcs_rst=4'hF`, `o_rxlane_done=0`, `o_cdr_align=0`. All synchronizer flops are 0 and every FSM is in PMA_RST with `cnt=0`.
- Synchronizer latency: a change on an input pin is visible in `lock_ok` and `o_cdr_align` 2 rising edges later.
- After `rst` falls, `o_rxlane_pma_rst` stays high for exactly `PMA_RST_CYC` rising edges.
- Minimum time from `pma_rst` falling to `done` rising, with lock already present:
  - 1 edge (WAIT_LOCK to STABLE), then `CDR_STABLE_CYC` edges, then `PCS_RST_CYC` edges.
  - `o_rxlane_pcs_rst` falls on the same edge that `o_rxlane_done` rises.
- Loss of lock in DONE: `done` falls 3 edges after the pin drops (2 synchronizer edges plus 1 state edge). `pcs_rst` rises on that same edge.
- `i_rx_rst` is acted on in the same edge: PMA_RST is entered on the first rising edge that samples it high.
- A lock glitch of 1 cycle or longer at the synchronizer output during STABLE or PCS_RST restarts qualification from WAIT_LOCK.

## Test plan
Simulation parameters for all scenarios: PMA_RST_CYC=4, CDR_STABLE_CYC=8, PCS_RST_CYC=4, CDR_TIMEOUT_CYC=32.

- **Reset and clean bring-up.** Release `rst` with all lock inputs at 1. Require:
  - `pma_rst` high for 4 edges, then low.
  - `done` rising exactly 1+8+4 = 13 edges after `pma_rst` falls.
  - `o_cdr_align=4'hF`.
- **Timeout retry.** Hold `i_cdr_align[1]=0`. Require lane 1 to re-enter PMA_RST after 32 WAIT_LOCK edges, `pma_rst[1]` to pulse 4 edges, and the cycle to repeat. Lanes 0, 2 and 3 reach `done` unaffected.
- **Glitch during STABLE.** Drop `i_cdr_align[2]` for 1 cycle after 5 STABLE edges. Require lane 2 to return to WAIT_LOCK and `done[2]` to rise 8+4+1 edges after lock returns, not earlier.
- **Loss of PLL lock in DONE.** Drop `i_pll_lock[0]`. Require `done[0]` 1→0 and `pma_rst[0]` 0→1, both exactly 3 edges later. With `i_sigdet[3]` dropped instead, `pma_rst[3]` stays 0 and only `pcs_rst[3]` rises.
- **Soft reset mid-sequence.** Assert `i_rx_rst[3]` for 6 cycles while lane 3 is in PCS_RST. Require `pma_rst[3]` high from the first sampled edge through 4 edges after release, then full re-sequencing.
- **Disabled lane and async reset.** With CH1_RX_ENABLE="FALSE", require lane 1 outputs constant 1/1/0 and `o_cdr_align[1]=0` whatever its inputs do. Assert `rst` mid-DONE and require all outputs to take their reset values with no clock edge.
